mem_access_ctrl: RTL and testbench

Memory-stage access sequencer for the pipelined core. It sits between the EX/MEM pipeline register outputs and a request/acknowledge data-memory bus. It turns each load or store in the M stage into exactly one bus transaction and holds the pipeline stall while that transaction is outstanding. It also returns aligned, extended load data, flags misaligned accesses and times out unresponsive transactions.

---
 rtl/mem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer: one bus transaction per M-stage load/store,
// pipeline stall while outstanding, load extraction, misalign and timeout flags.
module mem_access_ctrl #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             memreadM,
   input  logic             memwriteM,
   input  logic [2:0]       memctrlM,
   input  logic [WIDTH-1:0] aluresultM,
   input  logic [WIDTH-1:0] writedataM,
   input  logic             flushM,
   output logic             bus_req,
   output logic             bus_we,
   output logic [WIDTH-1:0] bus_addr,
   output logic [3:0]       bus_be,
   output logic [WIDTH-1:0] bus_wdata,
   input  logic             bus_ack,
   input  logic [WIDTH-1:0] bus_rdata,
   output logic             stallM,
   output logic [WIDTH-1:0] readdataM,
   output logic             misalignM,
   output logic             errM
);

   // state | meaning
   // IDLE  | waiting for an M-stage load/store; misaligned ones are flagged here
   // BUSY  | bus_req held, waiting for bus_ack or timeout
   // DONE  | stall released for one cycle so the instruction leaves M
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [2:0]       ctrl_q;
   logic [1:0]       off_q;

   logic             acc, is_w, is_h, mis;
   logic             start, mis_hit, ack_hit, tmo_hit;
   logic [3:0]       be_nxt;
   logic [WIDTH-1:0] wdata_nxt;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [WIDTH-1:0] rdata_ext;

   always_comb begin
      acc    = (memreadM | memwriteM) & ~flushM;
      is_w   = memctrlM[1];
      is_h   = (memctrlM[1:0] == 2'b01);
      mis    = (is_h & aluresultM[0]) | (is_w & (aluresultM[1:0] != 2'b00));
      be_nxt = 4'b0001 << aluresultM[1:0];
      wdata_nxt = {4{writedataM[7:0]}};
      if (is_w) begin
         be_nxt    = 4'b1111;
         wdata_nxt = writedataM;
      end else if (is_h) begin
         be_nxt    = 4'b0011 << aluresultM[1:0];
         wdata_nxt = {2{writedataM[15:0]}};
      end
   end

   // Extraction uses the latched width/offset, not the live pipeline fields.
   always_comb begin
      byte_v = bus_rdata[{off_q, 3'b000} +: 8];
      half_v = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (ctrl_q[1:0])
         2'b00:   rdata_ext = {{24{~ctrl_q[2] & byte_v[7]}}, byte_v};
         2'b01:   rdata_ext = {{16{~ctrl_q[2] & half_v[15]}}, half_v};
         default: rdata_ext = bus_rdata;
      endcase
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      mis_hit   = 1'b0;
      ack_hit   = 1'b0;
      tmo_hit   = 1'b0;
      stallM    = 1'b0;
      case (state)
         IDLE: begin
            if (acc && mis) begin
               mis_hit = 1'b1;
            end else if (acc) begin
               start     = 1'b1;
               stallM    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            stallM = 1'b1;
            if (bus_ack) begin
               ack_hit   = 1'b1;
               state_nxt = DONE;
            end else if (cnt == CNT_LAST) begin
               tmo_hit   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         ctrl_q    <= '0;
         off_q     <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= '0;
         bus_wdata <= '0;
         readdataM <= '0;
         misalignM <= 1'b0;
         errM      <= 1'b0;
      end else begin
         misalignM <= mis_hit;
         errM      <= tmo_hit;
         if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= memwriteM;
            bus_addr  <= {aluresultM[WIDTH-1:2], 2'b00};
            bus_be    <= be_nxt;
            bus_wdata <= wdata_nxt;
            ctrl_q    <= memctrlM;
            off_q     <= aluresultM[1:0];
            cnt       <= '0;
         end
         if (mis_hit && !memwriteM) readdataM <= '0;
         if (state == BUSY && !ack_hit && !tmo_hit) cnt <= cnt + 1'b1;
         if (ack_hit) begin
            bus_req <= 1'b0;
            if (!bus_we) readdataM <= rdata_ext;
         end
         if (tmo_hit) begin
            bus_req   <= 1'b0;
            readdataM <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed table-driven bench for mem_access_ctrl with reset and flush sequences.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        memreadM = 1'b0, memwriteM = 1'b0, flushM = 1'b0;
   logic [2:0]  memctrlM = '0;
   logic [31:0] aluresultM = '0, writedataM = '0;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        stallM;
   logic [31:0] readdataM;
   logic        misalignM, errM;

   int n_chk = 0;
   int n_fail = 0;

   mem_access_ctrl #(.WIDTH(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .memreadM(memreadM), .memwriteM(memwriteM), .memctrlM(memctrlM),
      .aluresultM(aluresultM), .writedataM(writedataM), .flushM(flushM),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .stallM(stallM), .readdataM(readdataM),
      .misalignM(misalignM), .errM(errM)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  ctrl;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_at;   // BUSY cycle index that is acked; 99 = never
      logic [3:0]  be;
      logic [31:0] baddr;
      logic [31:0] bwdata;
      logic        we;
      int          stall;
      logic [31:0] rdexp;
      logic        mis;
      logic        err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int  stall_cnt = 0;
      int  busy = 0;
      logic done = 1'b0;
      @(posedge clk); #1;
      memreadM = v.rd; memwriteM = v.wr; memctrlM = v.ctrl;
      aluresultM = v.addr; writedataM = v.wdata; flushM = 1'b0;
      bus_ack = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (stallM) begin
            stall_cnt++;
            if (bus_req) begin
               chk($sformatf("v%0d addr", idx), bus_addr, v.baddr);
               chk($sformatf("v%0d be", idx), {28'd0, bus_be}, {28'd0, v.be});
               chk($sformatf("v%0d wdata", idx), bus_wdata, v.bwdata);
               chk($sformatf("v%0d we", idx), {31'd0, bus_we}, {31'd0, v.we});
               bus_ack = (busy == v.ack_at);
               bus_rdata = v.rdata;
               busy++;
            end
         end else begin
            done = 1'b1;
         end
      end
      bus_ack = 1'b0;
      chk($sformatf("v%0d finished", idx), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d stall cycles", idx), stall_cnt, v.stall);
      if (v.stall > 0) chk($sformatf("v%0d req cycles", idx), busy, v.stall - 1);
      else chk($sformatf("v%0d req idle", idx), {31'd0, bus_req}, 32'd0);
      chk($sformatf("v%0d errM", idx), {31'd0, errM}, {31'd0, v.err});
      @(posedge clk); #1;
      memreadM = 1'b0; memwriteM = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d misalignM", idx), {31'd0, misalignM}, {31'd0, v.mis});
      chk($sformatf("v%0d readdataM", idx), readdataM, v.rdexp);
      chk($sformatf("v%0d errM low", idx), {31'd0, errM}, 32'd0);
      chk($sformatf("v%0d stall low", idx), {31'd0, stallM}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d misalign low", idx), {31'd0, misalignM}, 32'd0);
   endtask

   vec_t vecs[15];

   initial begin
      //          rd  wr  ctrl    addr          wdata         rdata         ack be       baddr         bwdata        we  stall rdexp        mis err
      vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,  4'b1111, 32'h100, 32'h0,        0, 2,  32'hDEADBEEF, 0, 0};
      vecs[1]  = '{0, 1, 3'b000, 32'h203, 32'h000000A5, 32'h0,        3,  4'b1000, 32'h200, 32'hA5A5A5A5, 1, 5,  32'hDEADBEEF, 0, 0};
      vecs[2]  = '{1, 0, 3'b000, 32'h2,   32'h0,        32'h0080FF00, 0,  4'b0100, 32'h0,   32'h0,        0, 2,  32'hFFFFFF80, 0, 0};
      vecs[3]  = '{1, 0, 3'b100, 32'h2,   32'h0,        32'h0080FF00, 0,  4'b0100, 32'h0,   32'h0,        0, 2,  32'h00000080, 0, 0};
      vecs[4]  = '{1, 0, 3'b001, 32'h2,   32'h0,        32'h80010000, 0,  4'b1100, 32'h0,   32'h0,        0, 2,  32'hFFFF8001, 0, 0};
      vecs[5]  = '{1, 0, 3'b101, 32'h2,   32'h0,        32'h80010000, 1,  4'b1100, 32'h0,   32'h0,        0, 3,  32'h00008001, 0, 0};
      vecs[6]  = '{0, 1, 3'b001, 32'h102, 32'h00001234, 32'h0,        1,  4'b1100, 32'h100, 32'h12341234, 1, 3,  32'h00008001, 0, 0};
      vecs[7]  = '{1, 0, 3'b010, 32'h300, 32'h0,        32'h55555555, 99, 4'b1111, 32'h300, 32'h0,        0, 17, 32'h0,        0, 1};
      vecs[8]  = '{1, 0, 3'b001, 32'h0,   32'h0,        32'h1234ABCD, 2,  4'b0011, 32'h0,   32'h0,        0, 4,  32'hFFFFABCD, 0, 0};
      vecs[9]  = '{1, 0, 3'b100, 32'h3,   32'h0,        32'h9A000000, 0,  4'b1000, 32'h0,   32'h0,        0, 2,  32'h0000009A, 0, 0};
      vecs[10] = '{1, 0, 3'b000, 32'h1,   32'h0,        32'h00007F00, 0,  4'b0010, 32'h0,   32'h0,        0, 2,  32'h0000007F, 0, 0};
      vecs[11] = '{1, 0, 3'b010, 32'h104, 32'h0,        32'h11223344, 1,  4'b1111, 32'h104, 32'h0,        0, 3,  32'h11223344, 0, 0};
      vecs[12] = '{1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0,  4'b0000, 32'h0,   32'h0,        0, 0,  32'h0,        1, 0};
      vecs[13] = '{0, 1, 3'b001, 32'h101, 32'hBEEF,     32'h0,        0,  4'b0000, 32'h0,   32'h0,        0, 0,  32'h0,        1, 0};
      vecs[14] = '{1, 1, 3'b010, 32'h10,  32'hCAFEF00D, 32'h0,        2,  4'b1111, 32'h10,  32'hCAFEF00D, 1, 4,  32'h0,        0, 0};

      #12;
      chk("reset req", {31'd0, bus_req}, 32'd0);
      chk("reset stall", {31'd0, stallM}, 32'd0);
      chk("reset readdata", readdataM, 32'd0);
      chk("reset addr", bus_addr, 32'd0);
      chk("reset flags", {30'd0, misalignM, errM}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

      // Asynchronous reset in the second BUSY cycle.
      @(posedge clk); #1;
      memreadM = 1'b1; memctrlM = 3'b010; aluresultM = 32'h400;
      @(negedge clk);
      @(negedge clk);
      chk("rst seq req busy1", {31'd0, bus_req}, 32'd1);
      @(negedge clk);
      chk("rst seq req busy2", {31'd0, bus_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst async req", {31'd0, bus_req}, 32'd0);
      chk("rst async be", {28'd0, bus_be}, 32'd0);
      chk("rst async addr", bus_addr, 32'd0);
      chk("rst async readdata", readdataM, 32'd0);
      chk("rst async stall with acc", {31'd0, stallM}, 32'd1);
      memreadM = 1'b0;
      #1;
      chk("rst async stall no acc", {31'd0, stallM}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post rst req", {31'd0, bus_req}, 32'd0);
         chk("post rst stall", {31'd0, stallM}, 32'd0);
      end

      // Flushed load must not start a transaction.
      @(posedge clk); #1;
      memreadM = 1'b1; flushM = 1'b1; memctrlM = 3'b010; aluresultM = 32'h500;
      repeat (3) begin
         @(negedge clk);
         chk("flush req", {31'd0, bus_req}, 32'd0);
         chk("flush stall", {31'd0, stallM}, 32'd0);
         chk("flush misalign", {31'd0, misalignM}, 32'd0);
      end
      @(posedge clk); #1;
      memreadM = 1'b0; flushM = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
